// File: rtl/uart_cmd_ctrl.sv
// Frames UART receiver bytes into DDR read/write commands and issues them
// over a valid/ready handshake, flagging bad opcodes, timeouts and overruns.
module uart_cmd_ctrl #(
    parameter int         ADDR_BYTES   = 4,
    parameter int         DATA_BYTES   = 16,
    parameter int         TIMEOUT_CLKS = 86800,
    parameter logic [7:0] OP_WRITE     = 8'hA5,
    parameter logic [7:0] OP_READ      = 8'h5A
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rx_dv,
    input  logic [7:0]              i_rx_byte,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic                    o_cmd_we,
    output logic [8*ADDR_BYTES-1:0] o_cmd_addr,
    output logic [8*DATA_BYTES-1:0] o_cmd_wdata,
    output logic                    o_busy,
    output logic                    o_err_opcode,
    output logic                    o_err_timeout,
    output logic                    o_err_overrun
);

    localparam int AW        = 8 * ADDR_BYTES;
    localparam int DW        = 8 * DATA_BYTES;
    localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
    localparam int TMO_W     = $clog2(TIMEOUT_CLKS) + 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_cmd_valid;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_busy;
    logic             r_err_opcode;
    logic             r_err_timeout;
    logic             r_err_overrun;

    logic w_is_opcode;
    logic w_tmo_expired;
    logic w_handshake;

    assign w_is_opcode   = (i_rx_byte == OP_WRITE) || (i_rx_byte == OP_READ);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_tmo_expired = (r_tmo == TMO_LAST) && !i_rx_dv;
    assign w_handshake   = r_cmd_valid && i_cmd_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_cmd_valid   <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_busy        <= 1'b0;
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_rx_dv) begin
                        if (w_is_opcode) begin
                            r_we    <= (i_rx_byte == OP_WRITE);
                            r_addr  <= '0;
                            r_wdata <= '0;
                            r_cnt   <= '0;
                            r_tmo   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ADDR;
                        end else begin
                            r_err_opcode <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (i_rx_dv) begin
                        r_addr <= AW'({r_addr, i_rx_byte});
                        r_tmo  <= '0;
                        if (r_cnt == ADDR_LAST) begin
                            r_cnt <= '0;
                            if (r_we) begin
                                r_state <= DATA;
                            end else begin
                                r_cmd_valid <= 1'b1;
                                r_state     <= ISSUE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_addr        <= '0;
                        r_wdata       <= '0;
                        r_cnt         <= '0;
                        r_tmo         <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                DATA: begin
                    if (i_rx_dv) begin
                        r_wdata <= DW'({r_wdata, i_rx_byte});
                        r_tmo   <= '0;
                        if (r_cnt == DATA_LAST) begin
                            r_cnt       <= '0;
                            r_cmd_valid <= 1'b1;
                            r_state     <= ISSUE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_tmo_expired) begin
                        r_err_timeout <= 1'b1;
                        r_addr        <= '0;
                        r_wdata       <= '0;
                        r_cnt         <= '0;
                        r_tmo         <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                ISSUE: begin
                    // Bytes cannot be buffered while a command waits; drop and flag.
                    if (i_rx_dv) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (w_handshake) begin
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_we      = r_we;
    assign o_cmd_addr    = r_addr;
    assign o_cmd_wdata   = r_wdata;
    assign o_busy        = r_busy;
    assign o_err_opcode  = r_err_opcode;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected commands and
// error pulses into queues, a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk;
    logic        rst_n;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic        i_cmd_ready;
    logic        o_cmd_valid;
    logic        o_cmd_we;
    logic [31:0] o_cmd_addr;
    logic [31:0] o_cmd_wdata;
    logic        o_busy;
    logic        o_err_opcode;
    logic        o_err_timeout;
    logic        o_err_overrun;

    uart_cmd_ctrl #(
        .ADDR_BYTES   (4),
        .DATA_BYTES   (4),
        .TIMEOUT_CLKS (TMO),
        .OP_WRITE     (8'hA5),
        .OP_READ      (8'h5A)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_dv       (i_rx_dv),
        .i_rx_byte     (i_rx_byte),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_cmd_we      (o_cmd_we),
        .o_cmd_addr    (o_cmd_addr),
        .o_cmd_wdata   (o_cmd_wdata),
        .o_busy        (o_busy),
        .o_err_opcode  (o_err_opcode),
        .o_err_timeout (o_err_timeout),
        .o_err_overrun (o_err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam int E_OPCODE  = 1;
    localparam int E_TIMEOUT = 2;
    localparam int E_OVERRUN = 3;

    cmd_t q_cmd[$];
    int   q_err[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_t c;
        c.we    = we;
        c.addr  = addr;
        c.wdata = wdata;
        q_cmd.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        tick();
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        $display("sent byte %02h busy=%0b valid=%0b", b, o_busy, o_cmd_valid);
    endtask

    task automatic check_err(input int kind, input string name);
        n_vec++;
        if (q_err.size() == 0) begin
            n_err++;
            $display("FAIL %s: got unexpected pulse, expected none", name);
        end else if (q_err[0] != kind) begin
            n_err++;
            $display("FAIL %s: got error kind %0d, expected kind %0d", name, kind, q_err[0]);
            void'(q_err.pop_front());
        end else begin
            void'(q_err.pop_front());
            $display("error pulse %s observed", name);
        end
    endtask

    // Monitor: command fields are compared every cycle valid is high, popped on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_cmd_valid) begin
                n_vec++;
                if (q_cmd.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_valid: got valid=1, expected no pending command");
                end else if (o_cmd_we !== q_cmd[0].we || o_cmd_addr !== q_cmd[0].addr ||
                             o_cmd_wdata !== q_cmd[0].wdata) begin
                    n_err++;
                    $display("FAIL cmd_fields: got we=%0b addr=%08h wdata=%08h, expected we=%0b addr=%08h wdata=%08h",
                             o_cmd_we, o_cmd_addr, o_cmd_wdata,
                             q_cmd[0].we, q_cmd[0].addr, q_cmd[0].wdata);
                    if (i_cmd_ready) void'(q_cmd.pop_front());
                end else if (i_cmd_ready) begin
                    $display("cmd accepted we=%0b addr=%08h wdata=%08h", o_cmd_we, o_cmd_addr, o_cmd_wdata);
                    void'(q_cmd.pop_front());
                end
            end
            if (o_err_opcode)  check_err(E_OPCODE,  "err_opcode");
            if (o_err_timeout) check_err(E_TIMEOUT, "err_timeout");
            if (o_err_overrun) check_err(E_OVERRUN, "err_overrun");
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_cmd_valid), 64'd0);
        chk({tag, "_busy"},  64'(o_busy),      64'd0);
        chk({tag, "_we"},    64'(o_cmd_we),    64'd0);
        chk({tag, "_addr"},  64'(o_cmd_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(o_cmd_wdata), 64'd0);
        chk({tag, "_errs"},  64'({o_err_opcode, o_err_timeout, o_err_overrun}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        i_rx_dv     = 1'b0;
        i_rx_byte   = 8'h00;
        i_cmd_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        tick();

        // Read frame, ready high: one-cycle valid right after the last byte.
        push_cmd(1'b0, 32'h12345678, 32'h0);
        send(8'h5A); send(8'h12); send(8'h34); send(8'h56);
        chk("read_busy", 64'(o_busy), 64'd1);
        chk("read_valid_early", 64'(o_cmd_valid), 64'd0);
        send(8'h78);
        chk("read_valid_latency", 64'(o_cmd_valid), 64'd1);
        tick();
        chk("read_valid_drop", 64'(o_cmd_valid), 64'd0);
        chk("read_idle", 64'(o_busy), 64'd0);

        // Write frame held by ready low for 20 cycles.
        i_cmd_ready = 1'b0;
        push_cmd(1'b1, 32'h00000100, 32'hDEADBEEF);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("write_valid_latency", 64'(o_cmd_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("write_valid_hold", 64'(o_cmd_valid), 64'd1);
        end
        i_cmd_ready = 1'b1;
        tick();
        chk("write_valid_drop", 64'(o_cmd_valid), 64'd0);
        chk("write_idle", 64'(o_busy), 64'd0);

        // Bad opcode, then a normal read.
        q_err.push_back(E_OPCODE);
        send(8'h3C);
        chk("badop_busy", 64'(o_busy), 64'd0);
        tick();
        push_cmd(1'b0, 32'hA1B2C3D4, 32'h0);
        send(8'h5A); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        chk("badop_read_valid", 64'(o_cmd_valid), 64'd1);
        tick();
        chk("badop_read_idle", 64'(o_busy), 64'd0);

        // Silence after a partial frame expires TMO edges after the last byte.
        q_err.push_back(E_TIMEOUT);
        send(8'h5A); send(8'h11); send(8'h22);
        repeat (TMO - 2) tick();
        chk("tmo_not_yet", 64'(o_busy), 64'd1);
        repeat (7) tick();
        chk("tmo_idle", 64'(o_busy), 64'd0);
        chk("tmo_no_valid", 64'(o_cmd_valid), 64'd0);

        // A byte landing exactly on the expiry edge keeps the frame alive.
        push_cmd(1'b0, 32'h11223344, 32'h0);
        send(8'h5A); send(8'h11);
        repeat (TMO - 1) tick();
        send(8'h22);
        chk("tmo_edge_busy", 64'(o_busy), 64'd1);
        send(8'h33); send(8'h44);
        chk("tmo_edge_valid", 64'(o_cmd_valid), 64'd1);
        tick();
        chk("tmo_edge_idle", 64'(o_busy), 64'd0);

        // Overrun during ISSUE and on the handshake cycle.
        i_cmd_ready = 1'b0;
        push_cmd(1'b1, 32'hAABBCCDD, 32'h01020304);
        send(8'hA5); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        repeat (3) tick();
        q_err.push_back(E_OVERRUN);
        send(8'h99);
        chk("ovr_valid_hold", 64'(o_cmd_valid), 64'd1);
        tick();
        q_err.push_back(E_OVERRUN);
        i_cmd_ready = 1'b1;
        send(8'h77);
        chk("ovr_valid_drop", 64'(o_cmd_valid), 64'd0);
        chk("ovr_idle", 64'(o_busy), 64'd0);
        chk("ovr_addr_retained", 64'(o_cmd_addr), 64'hAABBCCDD);
        chk("ovr_wdata_retained", 64'(o_cmd_wdata), 64'h01020304);
        tick();

        // Reset mid-frame.
        send(8'h5A); send(8'h01); send(8'h02); send(8'h03);
        chk("pre_reset_addr", 64'(o_cmd_addr), 64'h00010203);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_midframe");
        #2 rst_n = 1'b1;
        tick();

        // Reset while valid is held.
        i_cmd_ready = 1'b0;
        push_cmd(1'b0, 32'h0A0B0C0D, 32'h0);
        send(8'h5A); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        chk("pre_reset_valid", 64'(o_cmd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_valid");
        q_cmd.delete();
        #2 rst_n = 1'b1;
        i_cmd_ready = 1'b1;
        tick();

        // Fresh write frame after reset.
        push_cmd(1'b1, 32'h00000004, 32'h11223344);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h04);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("post_reset_valid", 64'(o_cmd_valid), 64'd1);
        tick();
        chk("post_reset_idle", 64'(o_busy), 64'd0);

        repeat (3) tick();
        chk("cmd_queue_drained", 64'(q_cmd.size()), 64'd0);
        chk("err_queue_drained", 64'(q_err.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
